// File: rtl/mux_stream_pkg.sv
// Shared types and constants for the N:1 streaming multiplexer.
package mux_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_sel_core.sv
// Combinational CHANNELS:1 selector with out-of-range (and, under MUX_STREAM_MASK_EN, mask) detect.
module mux_sel_core #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          idx,
`ifdef MUX_STREAM_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]          data_c,
    output logic                      err_c
);

    // Invalid or disabled channels yield zero data with the error flag set.
    always_comb begin
        data_c = '0;
        err_c  = (32'(idx) >= CHANNELS);
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == SEL_W'(i)) begin
`ifdef MUX_STREAM_MASK_EN
                if (ch_mask[i])
                    err_c = 1'b1;
                else
`endif
                    data_c = din[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_stream_nto1.sv
// Registered N:1 multiplexer with valid/ready output; MANUAL select or round-robin SCAN with dwell.
// Optional channel masking is built when MUX_STREAM_MASK_EN is defined.
module mux_stream_nto1
    import mux_stream_pkg::*;
#(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 1,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      en,
`ifdef MUX_STREAM_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic                      sel_err
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [WIDTH-1:0]   y_d;
    logic [SEL_W-1:0]   y_ch_d;
    logic               y_valid_d;
    logic               sel_err_d;

    logic [SEL_W-1:0]   idx_c;
    logic [WIDTH-1:0]   data_c;
    logic               err_c;
    logic [SEL_W-1:0]   nxt_ptr_c;
    logic               scan_ok_c;
    logic               capture_c;

    // One selector serves both modes: the scan pointer or the manual select.
    assign idx_c = (state_q == SCAN) ? ptr_q : sel;

    mux_sel_core #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_sel_core (
        .din     (din),
        .idx     (idx_c),
`ifdef MUX_STREAM_MASK_EN
        .ch_mask (ch_mask),
`endif
        .data_c  (data_c),
        .err_c   (err_c)
    );

`ifdef MUX_STREAM_MASK_EN
    int unsigned cand;
    logic        found;

    // Next enabled channel after ptr, wrapping; stays put if none is enabled.
    always_comb begin
        nxt_ptr_c = ptr_q;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = (32'(ptr_q) + 32'(k)) % CHANNELS;
            if (!found && !ch_mask[cand]) begin
                nxt_ptr_c = SEL_W'(cand);
                found     = 1'b1;
            end
        end
    end

    assign scan_ok_c = ~&ch_mask;
`else
    assign nxt_ptr_c = (ptr_q == SEL_W'(CHANNELS - 1)) ? '0 : ptr_q + 1'b1;
    assign scan_ok_c = 1'b1;
`endif

    // A new beat may load whenever the output slot is empty or being drained.
    assign capture_c = (state_q != IDLE) && (!y_valid || y_ready);

    // Next-state and output-register logic.
    always_comb begin
        state_d   = IDLE;
        ptr_d     = ptr_q;
        dwell_d   = dwell_q;
        y_d       = y;
        y_ch_d    = y_ch;
        y_valid_d = y_valid;
        sel_err_d = sel_err;

        if (en)
            state_d = (mode == MODE_SCAN) ? SCAN : MANUAL;

        if (y_valid && y_ready)
            y_valid_d = 1'b0;

        case (state_q)
            MANUAL: begin
                if (capture_c) begin
                    y_d       = data_c;
                    y_ch_d    = sel;
                    y_valid_d = 1'b1;
                    sel_err_d = err_c;
                end
            end
            SCAN: begin
                if (capture_c && scan_ok_c) begin
                    y_d       = data_c;
                    y_ch_d    = ptr_q;
                    y_valid_d = 1'b1;
                    sel_err_d = 1'b0;
                    if (dwell_q == DW_W'(DWELL - 1)) begin
                        dwell_d = '0;
                        ptr_d   = nxt_ptr_c;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Switching from MANUAL into SCAN restarts the walk at channel 0.
        if (state_q == MANUAL && state_d == SCAN) begin
            ptr_d   = '0;
            dwell_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            dwell_q <= '0;
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
            y       <= y_d;
            y_ch    <= y_ch_d;
            y_valid <= y_valid_d;
            sel_err <= sel_err_d;
        end
    end

endmodule
